// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel streaming multiplexer.
// Mode encodings are fixed so producers and the consumer agree on them.
package mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2 for elaboration-time widths; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      result = ((32'sd1 <<< i) < value) ? (i + 1) : result;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority request search: the first requester at or after ptr wins,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_vld,
  output logic [SELW-1:0] grant_idx
);

  int w_idx;

  // Scan from the farthest position back to ptr so the nearest requester is written last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    w_idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx     = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      grant_vld = grant_vld | req[w_idx];
      grant_idx = req[w_idx] ? w_idx[SELW-1:0] : grant_idx;
    end
  end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready streaming mux with a single registered output stage,
// selectable between explicit channel select and round-robin arbitration.
module mux_stream_n
  import mux_pkg::*;
#(
  parameter int  WIDTH = 64,
  parameter int  N     = 4,
  localparam int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready
);

  logic             w_can_load;
  logic             w_grant_vld;
  logic [SELW-1:0]  w_grant_idx;
  logic [SELW-1:0]  w_src_idx;
  logic             w_src_ok;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_load_data;

  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_src;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (r_ptr),
    .grant_vld (w_grant_vld),
    .grant_idx (w_grant_idx)
  );

  assign w_can_load = !r_out_valid || out_ready;

  // Pick the candidate source channel for the current mode.
  always_comb begin
    w_src_idx = '0;
    w_src_ok  = 1'b0;
    if (mode == MODE_SELECT) begin
      w_src_idx = sel;
      w_src_ok  = (int'(sel) < N);
    end else begin
      w_src_idx = w_grant_idx;
      w_src_ok  = w_grant_vld;
    end
  end

  // One-hot ready toward the candidate; an out-of-range select or reset grants nobody.
  always_comb begin
    in_ready = '0;
    if (rst_n && w_src_ok) begin
      for (int i = 0; i < N; i++) begin
        in_ready[i] = (w_src_idx == SELW'(i)) ? w_can_load : 1'b0;
      end
    end else begin
      in_ready = '0;
    end
  end

  assign w_xfer = |(in_valid & in_ready);

  // Data mux for the candidate channel.
  always_comb begin
    w_load_data = '0;
    for (int i = 0; i < N; i++) begin
      w_load_data = (w_src_idx == SELW'(i)) ? in_data[i*WIDTH +: WIDTH] : w_load_data;
    end
  end

  assign w_ptr_nxt = (w_grant_idx == SELW'(N - 1)) ? '0 : (w_grant_idx + SELW'(1));

  // Output register and round-robin pointer; a load always wins over a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= w_load_data;
        r_out_src   <= w_src_idx;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      if (w_xfer && (mode == MODE_RR)) begin
        r_ptr <= w_ptr_nxt;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_stream_n.sv
// Self-checking bench for mux_stream_n: directed vector table, randomized run
// against a behavioural reference, and multi-cycle corner sequences.
module tb_mux_stream_n;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  logic [3*W-1:0] b_in_data;
  logic [2:0]     b_in_valid;
  logic [2:0]     b_in_ready;
  logic           b_mode;
  logic [1:0]     b_sel;
  logic [W-1:0]   b_out_data;
  logic           b_out_valid;
  logic [1:0]     b_out_src;
  logic           b_out_ready;

  mux_stream_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_src(out_src), .out_ready(out_ready)
  );

  mux_stream_n #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_src(b_out_src), .out_ready(b_out_ready)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: one held word plus the round-robin position.
  logic        m_valid;
  logic [63:0] m_data;
  int          m_src;
  int          m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  // Which channel the mux should offer ready to this cycle, from the mode rules.
  task automatic model_ready(output logic [N-1:0] r, output int g);
    logic can;
    r   = '0;
    g   = -1;
    can = !m_valid || out_ready;
    if (rst_n) begin
      if (mode == 1'b0) begin
        if (int'(sel) < N) g = int'(sel);
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      if (g >= 0 && can) r[g] = 1'b1;
    end
  endtask

  // One clock: check ready before the edge, advance the reference, check outputs after.
  task automatic cycle();
    logic [N-1:0] er;
    int           g;
    logic         xfer;
    #1;
    model_ready(er, g);
    chk("in_ready", 64'(in_ready), 64'(er));
    xfer = (g >= 0) && er[g] && in_valid[g];
    if (xfer) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_src   = g;
      if (mode == 1'b1) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_src", 64'(out_src), 64'(m_src));
    end
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [1:0]  exp_src;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  task automatic set_std_data();
    in_data = {64'd8, 64'd4, 64'd2, 64'd1};
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      vecs[i] = '{1'b0, 2'(i), 4'b1111, 2'(i), 64'd1 << i};
    end
    for (int i = 0; i < 8; i++) begin
      vecs[4+i] = '{1'b1, 2'd0, 4'b1111, 2'(i % 4), 64'd1 << (i % 4)};
    end
    for (int i = 0; i < 4; i++) begin
      vecs[12+i] = '{1'b1, 2'd0, 4'b1010, (i % 2 == 0) ? 2'd1 : 2'd3,
                     (i % 2 == 0) ? 64'd2 : 64'd8};
    end

    rst_n     = 1'b0;
    set_std_data();
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    b_in_data   = {64'h33, 64'h22, 64'h11};
    b_in_valid  = 3'b111;
    b_mode      = 1'b0;
    b_sel       = 2'd3;
    b_out_ready = 1'b1;
    model_reset();

    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    in_valid = 4'b1111;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Select sweep, round-robin fairness and sparse round-robin.
    for (int v = 0; v < 16; v++) begin
      mode      = vecs[v].mode;
      sel       = vecs[v].sel;
      in_valid  = vecs[v].valid;
      out_ready = 1'b1;
      cycle();
      chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_src", v), 64'(out_src), 64'(vecs[v].exp_src));
      chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
    end

    // Backpressure with data 4 held, then drain and load in the same cycle.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_data", out_data, 64'd4);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    sel = 2'd3; out_ready = 1'b1;
    cycle();
    chk("bp_release_data", out_data, 64'd8);
    chk("bp_release_src", 64'(out_src), 64'd3);

    // Randomized traffic against the reference.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end

    // Asynchronous reset while a word is held.
    set_std_data();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_src", 64'(out_src), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    chk("post_rst_src0", 64'(out_src), 64'd0);
    chk("post_rst_data0", out_data, 64'd1);
    cycle();
    chk("post_rst_src1", 64'(out_src), 64'd1);
    chk("post_rst_data1", out_data, 64'd2);

    // Three-channel instance: out-of-range select never accepts, in-range does.
    #1;
    chk("n3_bad_sel_ready", 64'(b_in_ready), 64'd0);
    chk("n3_bad_sel_valid", 64'(b_out_valid), 64'd0);
    b_sel = 2'd2;
    #1;
    chk("n3_sel2_ready", 64'(b_in_ready), 64'b100);
    @(posedge clk);
    #1;
    chk("n3_sel2_valid", 64'(b_out_valid), 64'd1);
    chk("n3_sel2_data", b_out_data, 64'h33);
    chk("n3_sel2_src", 64'(b_out_src), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_stream_n.md
# mux_stream_n

Parametrised N-channel, WIDTH-bit streaming multiplexer with a registered output and valid/ready handshakes on every channel. It operates in one of two modes: explicit select, or round-robin arbitration across the channels that are requesting. It is the successor to the fixed 4×64-bit combinational mux and sits between multiple producer datapaths and a single downstream consumer. It adds backpressure, source tagging and fair sharing, which the combinational version lacks.

## Interface
Parameters:
- WIDTH, 64, data width per channel
- N, 4, number of input channels, N ≥ 2; need not be a power of two
- SELW (localparam), $clog2(N), width of the select and source fields

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous and active-low
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready (combinational)
- mode  in  1  MODE_SELECT = 0, MODE_RR = 1
- sel  in  SELW  selected channel, used in MODE_SELECT only
- out_data  out  WIDTH  registered output data
- out_valid  out  1  registered output valid
- out_src  out  SELW  index of the channel that supplied out_data
- out_ready  in  1  downstream ready

## Operation
- Single output register: out_data, out_src and out_valid.
- can_load = !out_valid | out_ready.
- MODE_SELECT:
  - in_ready[sel] = can_load; every other in_ready bit is 0.
  - If sel ≥ N, all in_ready bits are 0 and nothing is accepted. This replaces the X default of the old mux.
- MODE_RR:
  - Pointer ptr ∈ [0, N-1].
  - Grant goes to the first i with in_valid[i] set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - in_ready[grant] = can_load; every other in_ready bit is 0.
  - If no channel is valid, there is no grant.
- Transfer in: in_valid[g] & in_ready[g]. It loads out_data = channel g, out_src = g, out_valid = 1.
- ptr advances to (g+1) mod N only on a transfer in during MODE_RR.
  - Wrap-around: N-1 → 0.
  - ptr holds in MODE_SELECT and on cycles with no transfer.
- Transfer out: out_valid & out_ready. If no load happens in the same cycle, out_valid clears.
- Simultaneous drain and load: the new word replaces the old one in that cycle, with no bubble.
- mode and sel are sampled every cycle. Changing them never alters a word already held in the output register.
- in_ready never depends combinationally on in_valid of the same channel in MODE_SELECT. In MODE_RR it depends on in_valid only through the grant.

## Timing
- Reset (asynchronous, rst_n low): out_valid = 0, out_data = 0, out_src = 0, ptr = 0, taking effect immediately without a clock.
  - Any word held when reset asserts is dropped.
  - in_ready is all 0 while rst_n is low.
- Latency: 1 cycle from the in_valid/in_ready transfer edge to out_valid high.
- Throughput: 1 word per cycle while out_ready stays high.
- Backpressure: while out_valid & !out_ready, out_data and out_src are held stable and all in_ready bits are 0.
- After reset release, the first transfer is possible on the first rising edge at which rst_n is high.

## Structure
- Shared package mux_pkg holds:
  - the constants MODE_SELECT and MODE_RR
  - a clog2 helper function
- Sub-module rr_arbiter:
  - inputs: req[N], ptr[SELW]
  - outputs: grant_vld, grant_idx[SELW]
  - purely combinational, rotate-priority search
- ptr and the output register live in mux_stream_n.

## Test plan
Channels 0–3 carry data 1, 2, 4, 8 (WIDTH=64, N=4) unless stated otherwise.
- Select sweep: MODE_SELECT, sel = 0, 1, 2, 3, all valids high, out_ready = 1 → out_data is 1, 2, 4, 8, each 1 cycle after sel is applied; out_src equals sel.
- Round-robin fairness: MODE_RR, all four valids held high for 8 cycles, out_ready = 1 → out_src sequence is 0, 1, 2, 3, 0, 1, 2, 3 and ptr wraps 3 → 0.
- Sparse RR: MODE_RR with only channels 1 and 3 valid → out_src alternates 1, 3, 1, 3; channels 0 and 2 never see in_ready.
- Backpressure: out_ready held low for 5 cycles with data 4 held → out_data stays 4 and out_valid stays 1; all in_ready bits are 0. On release, the next word is loaded in the same cycle (drain+load).
- Invalid select: N = 3, MODE_SELECT, sel = 3 → in_ready = 3'b000 and out_valid stays 0.
- Reset mid-operation: assert rst_n low between clock edges while out_valid = 1 → out_valid = 0, out_data = 0 and out_src = 0 immediately. After release, RR grants restart from channel 0.
